// File: rtl/depth_test_stage.sv
// depth_test_stage: z-buffer between the rasterizer and the shader/framebuffer.
// Define ZBUF_STATS_EN to add pass_count_out / reject_count_out counters.
module depth_test_stage #(
    parameter int FB_HRES = 320,
    parameter int FB_VRES = 180,
    parameter int ZWIDTH  = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       clear_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [$clog2(FB_HRES)-1:0] hcount_in,
    input  logic [$clog2(FB_VRES)-1:0] vcount_in,
    input  logic [ZWIDTH-1:0]          z_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(FB_HRES)-1:0] hcount_out,
    output logic [$clog2(FB_VRES)-1:0] vcount_out,
    output logic [ZWIDTH-1:0]          z_out,
    output logic                       clear_done_out
`ifdef ZBUF_STATS_EN
    ,
    output logic [31:0]                pass_count_out,
    output logic [31:0]                reject_count_out
`endif
);

    localparam int HW    = $clog2(FB_HRES);
    localparam int VW    = $clog2(FB_VRES);
    localparam int DEPTH = FB_HRES * FB_VRES;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [ZWIDTH-1:0] ZMAX = {1'b0, {(ZWIDTH-1){1'b1}}};
    localparam logic [AW-1:0]     LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            clear_done_q, clear_done_d;

    // S0: registered address and pixel fields
    logic              s0_valid_q;
    logic              s0_inr_q;
    logic [AW-1:0]     s0_addr_q;
    logic [HW-1:0]     s0_h_q;
    logic [VW-1:0]     s0_v_q;
    logic [ZWIDTH-1:0] s0_z_q;

    // S1: pixel fields alongside the RAM read data
    logic              s1_valid_q;
    logic              s1_inr_q;
    logic [AW-1:0]     s1_addr_q;
    logic [HW-1:0]     s1_h_q;
    logic [VW-1:0]     s1_v_q;
    logic [ZWIDTH-1:0] s1_z_q;
    logic [ZWIDTH-1:0] rdata_q;

    // Write history: entry 0 is the newest committed write
    logic              hist0_v_q, hist1_v_q;
    logic [AW-1:0]     hist0_addr_q, hist1_addr_q;
    logic [ZWIDTH-1:0] hist0_z_q, hist1_z_q;

    // S3: output register
    logic              out_valid_q;
    logic [HW-1:0]     out_h_q;
    logic [VW-1:0]     out_v_q;
    logic [ZWIDTH-1:0] out_z_q;

    logic [ZWIDTH-1:0] mem_q [DEPTH];

    logic              advance;
    logic              accept;
    logic              in_range_c;
    logic [AW-1:0]     addr_c;
    logic [ZWIDTH-1:0] stored_c;
    logic              pass_c;
    logic              wr_run_c;
    logic              we_c;
    logic              re_c;
    logic [AW-1:0]     waddr_c;
    logic [ZWIDTH-1:0] wdata_c;
    logic              pipe_empty;

    assign advance    = !out_valid_q || ready_in;
    assign ready_out  = (state_q == ST_RUN) && advance;
    assign accept     = valid_in && ready_out;
    assign pipe_empty = !s0_valid_q && !s1_valid_q && !out_valid_q;

    assign valid_out      = out_valid_q;
    assign hcount_out     = out_h_q;
    assign vcount_out     = out_v_q;
    assign z_out          = out_z_q;
    assign clear_done_out = clear_done_q;

    // Input decode: range check and linear depth-RAM address.
    always_comb begin
        in_range_c = (int'(hcount_in) < FB_HRES) &&
                     (int'(vcount_in) < FB_VRES);
        addr_c     = AW'(int'(vcount_in) * FB_HRES + int'(hcount_in));
    end

    // Depth test against the newest value for this address, strict signed.
    always_comb begin
        stored_c = rdata_q;
        if (hist1_v_q && (hist1_addr_q == s1_addr_q)) begin
            stored_c = hist1_z_q;
        end
        if (hist0_v_q && (hist0_addr_q == s1_addr_q)) begin
            stored_c = hist0_z_q;
        end
        pass_c   = s1_valid_q && s1_inr_q &&
                   ($signed(s1_z_q) < $signed(stored_c));
        wr_run_c = pass_c && advance;
    end

    // RAM port selection: clear sweep owns the write port in CLEAR.
    always_comb begin
        re_c = advance && s0_valid_q && s0_inr_q;
        if (state_q == ST_CLEAR) begin
            we_c    = 1'b1;
            waddr_c = clr_addr_q;
            wdata_c = ZMAX;
        end else begin
            we_c    = wr_run_c;
            waddr_c = s1_addr_q;
            wdata_c = s1_z_q;
        end
    end

    // Depth RAM: one write, one synchronous read; read data holds on stall.
    always_ff @(posedge clk_in) begin
        if (we_c) begin
            mem_q[waddr_c] <= wdata_c;
        end
        if (re_c) begin
            rdata_q <= mem_q[s0_addr_q];
        end
    end

    // Next state: clear sweep, run, and drain-before-clear.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clear_done_d = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == LAST) begin
                    clr_addr_d   = '0;
                    clear_done_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_in) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // State register; reset starts a full clear sweep.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Pixel pipeline: every stage moves together on advance, else holds.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s0_valid_q  <= 1'b0;
            s0_inr_q    <= 1'b0;
            s0_addr_q   <= '0;
            s0_h_q      <= '0;
            s0_v_q      <= '0;
            s0_z_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_inr_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_h_q      <= '0;
            s1_v_q      <= '0;
            s1_z_q      <= '0;
            out_valid_q <= 1'b0;
            out_h_q     <= '0;
            out_v_q     <= '0;
            out_z_q     <= '0;
        end else if (advance) begin
            s0_valid_q <= accept;
            if (accept) begin
                s0_inr_q  <= in_range_c;
                s0_addr_q <= addr_c;
                s0_h_q    <= hcount_in;
                s0_v_q    <= vcount_in;
                s0_z_q    <= z_in;
            end
            s1_valid_q  <= s0_valid_q;
            s1_inr_q    <= s0_inr_q;
            s1_addr_q   <= s0_addr_q;
            s1_h_q      <= s0_h_q;
            s1_v_q      <= s0_v_q;
            s1_z_q      <= s0_z_q;
            out_valid_q <= pass_c;
            if (pass_c) begin
                out_h_q <= s1_h_q;
                out_v_q <= s1_v_q;
                out_z_q <= s1_z_q;
            end
        end
    end

    // Write history for the bypass; flushed while the RAM is being cleared.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hist0_v_q    <= 1'b0;
            hist0_addr_q <= '0;
            hist0_z_q    <= '0;
            hist1_v_q    <= 1'b0;
            hist1_addr_q <= '0;
            hist1_z_q    <= '0;
        end else if (state_q == ST_CLEAR) begin
            hist0_v_q <= 1'b0;
            hist1_v_q <= 1'b0;
        end else if (advance) begin
            hist1_v_q    <= hist0_v_q;
            hist1_addr_q <= hist0_addr_q;
            hist1_z_q    <= hist0_z_q;
            hist0_v_q    <= wr_run_c;
            hist0_addr_q <= s1_addr_q;
            hist0_z_q    <= s1_z_q;
        end
    end

`ifdef ZBUF_STATS_EN
    logic [31:0] pass_cnt_q;
    logic [31:0] rej_cnt_q;
    logic        stats_clr_c;
    logic        decide_c;

    assign stats_clr_c      = (state_q == ST_DRAIN) && (state_d == ST_CLEAR);
    assign decide_c         = advance && s1_valid_q;
    assign pass_count_out   = pass_cnt_q;
    assign reject_count_out = rej_cnt_q;

    // Saturating pass/reject counters, zeroed when a clear sweep begins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pass_cnt_q <= '0;
            rej_cnt_q  <= '0;
        end else if (stats_clr_c) begin
            pass_cnt_q <= '0;
            rej_cnt_q  <= '0;
        end else if (decide_c) begin
            if (pass_c && (pass_cnt_q != '1)) begin
                pass_cnt_q <= pass_cnt_q + 32'd1;
            end
            if (!pass_c && (rej_cnt_q != '1)) begin
                rej_cnt_q <= rej_cnt_q + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counter state.
`endif

endmodule
